// File: rtl/video_timing_if.sv
// Raster coordinate and aligned video bundle between the timing
// generator and the downstream image/transmitter path.
interface video_timing_if #(
    parameter int BIT_WIDTH  = 12,
    parameter int BIT_HEIGHT = 11
);
    logic [BIT_WIDTH-1:0]  cx;
    logic [BIT_HEIGHT-1:0] cy;
    logic [23:0]           rgb_in;
    logic [23:0]           rgb_out;
    logic                  de;
    logic                  hsync;
    logic                  vsync;
    logic                  line_start;
    logic                  frame_start;
    logic [31:0]           frame_count;

    modport master (
        output cx, cy, rgb_out, de, hsync, vsync,
        output line_start, frame_start, frame_count,
        input  rgb_in
    );

    modport slave (
        input  cx, cy, rgb_out, de, hsync, vsync,
        input  line_start, frame_start, frame_count,
        output rgb_in
    );
endinterface

// File: rtl/video_timing_generator.sv
// Pixel-clock raster timing source: scan coordinates out, returned rgb
// realigned with de/hsync/vsync and frame/line markers.
module video_timing_generator #(
    parameter int FRAME_WIDTH    = 2200,
    parameter int FRAME_HEIGHT   = 1125,
    parameter int SCREEN_WIDTH   = 1920,
    parameter int SCREEN_HEIGHT  = 1080,
    parameter int H_FRONT_PORCH  = 88,
    parameter int H_SYNC_WIDTH   = 44,
    parameter int V_FRONT_PORCH  = 4,
    parameter int V_SYNC_WIDTH   = 5,
    parameter bit HSYNC_POLARITY = 1'b1,
    parameter bit VSYNC_POLARITY = 1'b1,
    parameter int BIT_WIDTH      = 12,
    parameter int BIT_HEIGHT     = 11,
    parameter int PIXEL_LATENCY  = 2
) (
    input  logic           pixel_clk,
    input  logic           reset,
    input  logic           enable,
    video_timing_if.master vid
);
    localparam int XW = BIT_WIDTH + 1;
    localparam int YW = BIT_HEIGHT + 1;

    localparam logic [BIT_WIDTH-1:0]  CX_LAST = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] CY_LAST = BIT_HEIGHT'(FRAME_HEIGHT - 1);

    localparam logic [XW-1:0] H_ACT  = XW'(SCREEN_WIDTH);
    localparam logic [XW-1:0] HS_BEG = XW'(SCREEN_WIDTH + H_FRONT_PORCH);
    localparam logic [XW-1:0] HS_END =
        XW'(SCREEN_WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [YW-1:0] V_ACT  = YW'(SCREEN_HEIGHT);
    localparam logic [YW-1:0] VS_BEG = YW'(SCREEN_HEIGHT + V_FRONT_PORCH);
    localparam logic [YW-1:0] VS_END =
        YW'(SCREEN_HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH);

    if (SCREEN_WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH > FRAME_WIDTH) begin : g_bad_h
        $error("horizontal timing does not fit in FRAME_WIDTH");
    end
    if (SCREEN_HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH > FRAME_HEIGHT) begin : g_bad_v
        $error("vertical timing does not fit in FRAME_HEIGHT");
    end
    if (FRAME_WIDTH > (1 << BIT_WIDTH)) begin : g_bad_bw
        $error("FRAME_WIDTH does not fit in BIT_WIDTH");
    end
    if (FRAME_HEIGHT > (1 << BIT_HEIGHT)) begin : g_bad_bh
        $error("FRAME_HEIGHT does not fit in BIT_HEIGHT");
    end
    if (PIXEL_LATENCY < 0) begin : g_bad_lat
        $error("PIXEL_LATENCY must be non-negative");
    end

    // Disable behaves like reset for everything except frame_count.
    logic clear;
    assign clear = reset | ~enable;

    logic [BIT_WIDTH-1:0]  cx_q;
    logic [BIT_HEIGHT-1:0] cy_q;

    // Raster scan counters; cy advances on the cx wrap.
    always_ff @(posedge pixel_clk) begin
        if (clear) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (cx_q == CX_LAST) begin
            cx_q <= '0;
            cy_q <= (cy_q == CY_LAST) ? '0 : cy_q + 1'b1;
        end else begin
            cx_q <= cx_q + 1'b1;
        end
    end

    logic [XW-1:0] cx_w;
    logic [YW-1:0] cy_w;
    assign cx_w = {1'b0, cx_q};
    assign cy_w = {1'b0, cy_q};

    logic de_raw, hs_raw, vs_raw, sol_raw, sof_raw;
    assign de_raw  = (cx_w < H_ACT) && (cy_w < V_ACT);
    assign hs_raw  = (cx_w >= HS_BEG) && (cx_w < HS_END);
    assign vs_raw  = (cy_w >= VS_BEG) && (cy_w < VS_END);
    assign sol_raw = de_raw && (cx_q == '0);
    assign sof_raw = sol_raw && (cy_q == '0);

    // Bundle order: {sof, sol, vs, hs, de}, all active-high internally.
    logic [4:0] raw;
    logic [4:0] dly;
    assign raw = {sof_raw, sol_raw, vs_raw, hs_raw, de_raw};

    if (PIXEL_LATENCY == 0) begin : g_nodly
        assign dly = raw;
    end else begin : g_dly
        logic [4:0] sr [PIXEL_LATENCY];

        // Delay the raw timing to match the image path latency.
        always_ff @(posedge pixel_clk) begin
            if (clear) begin
                for (int i = 0; i < PIXEL_LATENCY; i++) sr[i] <= '0;
            end else begin
                sr[0] <= raw;
                for (int i = 1; i < PIXEL_LATENCY; i++) sr[i] <= sr[i-1];
            end
        end

        assign dly = sr[PIXEL_LATENCY-1];
    end

    logic [23:0] rgb_q;
    logic        de_q, hs_q, vs_q, ls_q, fs_q;
    logic [31:0] fc_q;

    // Output register: capture pixel with its timing, apply sync polarity.
    always_ff @(posedge pixel_clk) begin
        if (clear) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~HSYNC_POLARITY;
            vs_q  <= ~VSYNC_POLARITY;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            rgb_q <= dly[0] ? vid.rgb_in : '0;
            de_q  <= dly[0];
            hs_q  <= dly[1] ? HSYNC_POLARITY : ~HSYNC_POLARITY;
            vs_q  <= dly[2] ? VSYNC_POLARITY : ~VSYNC_POLARITY;
            ls_q  <= dly[3];
            fs_q  <= dly[4];
        end
    end

    // Count frame_start pulses once each has been presented; survives disable.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            fc_q <= '0;
        end else if (fs_q) begin
            fc_q <= fc_q + 32'd1;
        end
    end

    assign vid.cx          = cx_q;
    assign vid.cy          = cy_q;
    assign vid.rgb_out     = rgb_q;
    assign vid.de          = de_q;
    assign vid.hsync       = hs_q;
    assign vid.vsync       = vs_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;
    assign vid.frame_count = fc_q;
endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator: default, mid-size and
// zero-latency rasters, disable and reset mid-pulse.
module tb_video_timing_generator;
    logic pixel_clk = 1'b0;
    logic reset     = 1'b1;
    logic enable    = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 pixel_clk = ~pixel_clk;

    video_timing_if #(.BIT_WIDTH(12), .BIT_HEIGHT(11)) v_def ();
    video_timing_if #(.BIT_WIDTH(12), .BIT_HEIGHT(11)) v_mid ();
    video_timing_if #(.BIT_WIDTH(12), .BIT_HEIGHT(11)) v_sm ();

    video_timing_generator u_def (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .enable    (enable),
        .vid       (v_def)
    );

    video_timing_generator #(
        .FRAME_WIDTH(40), .FRAME_HEIGHT(20),
        .SCREEN_WIDTH(24), .SCREEN_HEIGHT(12),
        .H_FRONT_PORCH(4), .H_SYNC_WIDTH(6),
        .V_FRONT_PORCH(2), .V_SYNC_WIDTH(3),
        .PIXEL_LATENCY(2)
    ) u_mid (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .enable    (enable),
        .vid       (v_mid)
    );

    video_timing_generator #(
        .FRAME_WIDTH(20), .FRAME_HEIGHT(10),
        .SCREEN_WIDTH(12), .SCREEN_HEIGHT(6),
        .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3),
        .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2),
        .PIXEL_LATENCY(0)
    ) u_sm (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .enable    (enable),
        .vid       (v_sm)
    );

    // Image controller stand-in: pixel = {cy, cx} of 2 cycles earlier.
    logic [23:0] d1_def, d2_def, d1_mid, d2_mid;
    always_ff @(posedge pixel_clk) begin
        d1_def <= {v_def.cy[7:0], 4'b0, v_def.cx};
        d2_def <= d1_def;
        d1_mid <= {v_mid.cy[7:0], 4'b0, v_mid.cx};
        d2_mid <= d1_mid;
    end
    assign v_def.rgb_in = d2_def;
    assign v_mid.rgb_in = d2_mid;
    assign v_sm.rgb_in  = {v_sm.cy[7:0], 4'b0, v_sm.cx};

    logic [83:0] act_def, act_mid, act_sm;
    assign act_def = {v_def.cx, v_def.cy, v_def.de, v_def.hsync,
                      v_def.vsync, v_def.line_start, v_def.frame_start,
                      v_def.rgb_out, v_def.frame_count};
    assign act_mid = {v_mid.cx, v_mid.cy, v_mid.de, v_mid.hsync,
                      v_mid.vsync, v_mid.line_start, v_mid.frame_start,
                      v_mid.rgb_out, v_mid.frame_count};
    assign act_sm  = {v_sm.cx, v_sm.cy, v_sm.de, v_sm.hsync,
                      v_sm.vsync, v_sm.line_start, v_sm.frame_start,
                      v_sm.rgb_out, v_sm.frame_count};

    // Expected {cx,cy,de,hs,vs,ls,fs,rgb,fc} n cycles after raster start.
    function automatic logic [83:0] exp_vec(
        int n, int fw, int fh, int sw, int sh, int hfp, int hsw,
        int vfp, int vsw, int lat, int base
    );
        int m, pcx, pcy;
        logic de_e, hs_e, vs_e, ls_e, fs_e;
        logic [23:0] rgb_e;
        logic [31:0] fc_e;
        logic [11:0] ecx;
        logic [10:0] ecy;
        ecx = 12'(n % fw);
        ecy = 11'((n / fw) % fh);
        de_e = 1'b0; hs_e = 1'b0; vs_e = 1'b0;
        ls_e = 1'b0; fs_e = 1'b0; rgb_e = '0;
        m = n - lat - 1;
        if (m >= 0) begin
            pcx  = m % fw;
            pcy  = (m / fw) % fh;
            de_e = (pcx < sw) && (pcy < sh);
            hs_e = (pcx >= sw + hfp) && (pcx < sw + hfp + hsw);
            vs_e = (pcy >= sh + vfp) && (pcy < sh + vfp + vsw);
            ls_e = de_e && (pcx == 0);
            fs_e = ls_e && (pcy == 0);
            if (de_e) rgb_e = {8'(pcy), 16'(pcx)};
        end
        if (n <= lat + 1) fc_e = 32'(base);
        else fc_e = 32'(base + (n - lat - 2) / (fw * fh) + 1);
        return {ecx, ecy, de_e, hs_e, vs_e, ls_e, fs_e, rgb_e, fc_e};
    endfunction

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic start_all();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if (act_def !== 84'd0) begin
            errors++;
            $display("FAIL reset_def got %h want %h", act_def, 84'd0);
        end
        checks++;
        if (act_mid !== 84'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", act_mid, 84'd0);
        end
        checks++;
        if (act_sm !== 84'd0) begin
            errors++;
            $display("FAIL reset_sm got %h want %h", act_sm, 84'd0);
        end
    endtask

    task automatic test_raster_default();
        logic [83:0] e;
        int de_cnt;
        start_all();
        de_cnt = 0;
        for (int n = 0; n < 6600; n++) begin
            e = exp_vec(n, 2200, 1125, 1920, 1080, 88, 44, 4, 5, 2, 0);
            checks++;
            if (act_def !== e) begin
                errors++;
                $display("FAIL raster_def n=%0d got %h want %h", n, act_def, e);
            end
            if (n >= 3 && n < 2203 && v_def.de) de_cnt++;
            tick();
        end
        checks++;
        if (de_cnt !== 1920) begin
            errors++;
            $display("FAIL de_per_line got %0d want 1920", de_cnt);
        end
    endtask

    task automatic test_frame_mid();
        logic [83:0] e;
        int de_cnt, vs_cnt;
        start_all();
        de_cnt = 0;
        vs_cnt = 0;
        for (int n = 0; n < 2500; n++) begin
            e = exp_vec(n, 40, 20, 24, 12, 4, 6, 2, 3, 2, 0);
            checks++;
            if (act_mid !== e) begin
                errors++;
                $display("FAIL frame_mid n=%0d got %h want %h", n, act_mid, e);
            end
            if (n >= 3 && n < 803) begin
                if (v_mid.de) de_cnt++;
                if (v_mid.vsync) vs_cnt++;
            end
            tick();
        end
        checks++;
        if (de_cnt !== 288) begin
            errors++;
            $display("FAIL de_per_frame got %0d want 288", de_cnt);
        end
        checks++;
        if (vs_cnt !== 120) begin
            errors++;
            $display("FAIL vs_per_frame got %0d want 120", vs_cnt);
        end
    endtask

    task automatic test_latency0_small();
        logic [83:0] e;
        start_all();
        for (int n = 0; n < 450; n++) begin
            e = exp_vec(n, 20, 10, 12, 6, 2, 3, 1, 2, 0, 0);
            checks++;
            if (act_sm !== e) begin
                errors++;
                $display("FAIL lat0_sm n=%0d got %h want %h", n, act_sm, e);
            end
            tick();
        end
    endtask

    task automatic test_disable();
        logic [83:0] e;
        logic [83:0] held;
        start_all();
        repeat (2700) tick();
        e = exp_vec(2700, 2200, 1125, 1920, 1080, 88, 44, 4, 5, 2, 0);
        checks++;
        if (act_def !== e) begin
            errors++;
            $display("FAIL pre_disable got %h want %h", act_def, e);
        end
        enable = 1'b0;
        held = {12'd0, 11'd0, 5'd0, 24'd0, 32'd1};
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (act_def !== held) begin
                errors++;
                $display("FAIL disabled k=%0d got %h want %h", k, act_def, held);
            end
        end
        enable = 1'b1;
        for (int n = 0; n < 2300; n++) begin
            e = exp_vec(n, 2200, 1125, 1920, 1080, 88, 44, 4, 5, 2, 1);
            checks++;
            if (act_def !== e) begin
                errors++;
                $display("FAIL reenable n=%0d got %h want %h", n, act_def, e);
            end
            tick();
        end
    endtask

    task automatic test_disable_vsync();
        logic [83:0] held;
        start_all();
        repeat (600) tick();
        checks++;
        if (v_mid.vsync !== 1'b1) begin
            errors++;
            $display("FAIL vs_before_disable got %b want 1", v_mid.vsync);
        end
        enable = 1'b0;
        tick();
        held = {12'd0, 11'd0, 5'd0, 24'd0, 32'd1};
        checks++;
        if (act_mid !== held) begin
            errors++;
            $display("FAIL vs_after_disable got %h want %h", act_mid, held);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_hsync();
        logic [83:0] e;
        start_all();
        repeat (2012) tick();
        checks++;
        if (v_def.hsync !== 1'b1) begin
            errors++;
            $display("FAIL hs_before_reset got %b want 1", v_def.hsync);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (act_def !== 84'd0) begin
            errors++;
            $display("FAIL hs_reset got %h want %h", act_def, 84'd0);
        end
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            e = exp_vec(n, 2200, 1125, 1920, 1080, 88, 44, 4, 5, 2, 0);
            checks++;
            if (act_def !== e) begin
                errors++;
                $display("FAIL post_reset n=%0d got %h want %h", n, act_def, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raster_default();
        test_frame_mid();
        test_latency0_small();
        test_disable();
        test_disable_vsync();
        test_reset_mid_hsync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Pixel-clock raster timing source placed directly upstream of the image controller.
- Generates the cx/cy scan coordinates that the image sender consumes.
- Takes the returned rgb, delays de/hsync/vsync to line up with it, and drives the aligned video stream to the HDMI/DP transmitter.
- Also produces frame/line markers and a frame counter for TimeController-side logging.

Parameters:
- FRAME_WIDTH, 2200, total pixels per line (active + blanking)
- FRAME_HEIGHT, 1125, total lines per frame
- SCREEN_WIDTH, 1920, active pixels per line
- SCREEN_HEIGHT, 1080, active lines per frame
- H_FRONT_PORCH, 88, pixels from end of active line to hsync start
- H_SYNC_WIDTH, 44, hsync pulse width in pixels
- V_FRONT_PORCH, 4, lines from end of active frame to vsync start
- V_SYNC_WIDTH, 5, vsync pulse width in lines
- HSYNC_POLARITY, 1, active level of hsync (1 = active-high)
- VSYNC_POLARITY, 1, active level of vsync
- BIT_WIDTH, 12, cx width
- BIT_HEIGHT, 11, cy width
- PIXEL_LATENCY, 2, cycles from cx/cy presented to matching rgb_in valid; 0 legal

Ports:
- pixel_clk  in  1  pixel clock; all logic in this domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  run raster; low = hold at origin, blanked
- cx  out  BIT_WIDTH  current horizontal coordinate
- cy  out  BIT_HEIGHT  current vertical coordinate
- rgb_in  in  24  pixel from image controller, valid PIXEL_LATENCY cycles after cx/cy
- rgb_out  out  24  aligned pixel; 0 outside active area
- de  out  1  aligned data enable
- hsync  out  1  aligned horizontal sync
- vsync  out  1  aligned vertical sync
- line_start  out  1  one-cycle pulse, aligned with first active pixel of each line
- frame_start  out  1  one-cycle pulse, aligned with aligned pixel (0,0)
- frame_count  out  32  completed frame_start count, wraps at 2^32

Behaviour:
- Reset values: cx=0, cy=0, rgb_out=0, de=0, line_start=0, frame_start=0, frame_count=0; hsync=~HSYNC_POLARITY and vsync=~VSYNC_POLARITY (inactive). All delay-line stages cleared.
- Counters (enable=1):
  - cx increments each cycle; at FRAME_WIDTH-1 it wraps to 0 and cy increments.
  - cy wraps from FRAME_HEIGHT-1 to 0 on the same cycle cx wraps.
- Raw timing, combinational from the current cx/cy:
  - de_raw = (cx < SCREEN_WIDTH) && (cy < SCREEN_HEIGHT)
  - hs_raw active when SCREEN_WIDTH+H_FRONT_PORCH <= cx < SCREEN_WIDTH+H_FRONT_PORCH+H_SYNC_WIDTH
  - vs_raw active when SCREEN_HEIGHT+V_FRONT_PORCH <= cy < SCREEN_HEIGHT+V_FRONT_PORCH+V_SYNC_WIDTH, for the entire line (no half-line offset)
  - sol_raw = de_raw && cx==0
  - sof_raw = sol_raw && cy==0
- Alignment:
  - Raw signals pass through a PIXEL_LATENCY-stage shift register, then one output register stage.
  - The same output register captures rgb_in: rgb_out = de_delayed ? rgb_in : 0.
  - Total latency from cx/cy to de/hsync/vsync/rgb_out = PIXEL_LATENCY+1 cycles.
- Polarity is applied at the output register only; internal stages are active-high.
- frame_count increments on the cycle frame_start is asserted.
- enable=0:
  - Next cycle, cx=cy=0; delay line and outputs cleared to reset values.
  - frame_count retained.
  - On enable rising, (0,0) is presented on the first enabled cycle; raster restarts cleanly.
- Reset has priority over enable. Reset or disable mid-sync pulse leaves no truncated pulse on the outputs: they go inactive the following cycle.
- Elaboration-time error if any of these fail:
  - SCREEN_WIDTH+H_FRONT_PORCH+H_SYNC_WIDTH <= FRAME_WIDTH
  - the same relation vertically (SCREEN_HEIGHT+V_FRONT_PORCH+V_SYNC_WIDTH <= FRAME_HEIGHT)
  - FRAME_WIDTH <= 2^BIT_WIDTH
  - FRAME_HEIGHT <= 2^BIT_HEIGHT

Test Plan:
- Defaults, reset released, enable=1 → cx runs 0..2199 and wraps; cy increments on each wrap; cy 1124→0 after 2,475,000 cycles; frame_count=1 at the second frame_start.
- Count de over one frame → exactly 2,073,600 cycles, 1920 contiguous per line, 1080 lines. hsync active 44 cycles starting 3 cycles after cx==2008. vsync active for lines 1084..1088 (5×2200 cycles).
- rgb_in driven as {cy_d[7:0], cx_d[15:0]} using cx/cy delayed 2 cycles → rgb_out equals that pattern on every de cycle and 0 elsewhere. frame_start coincides with the first de and rgb_out=24'h000000; line_start fires at each line's first de.
- PIXEL_LATENCY=0, small frame (FRAME_WIDTH=20, SCREEN_WIDTH=12, H_FRONT_PORCH=2, H_SYNC_WIDTH=3) → de rises 1 cycle after cx==0; hsync spans raw cx 14..16.
- enable dropped at cx=500, cy=300 → next cycle cx=cy=0 and de=0 with hsync/vsync inactive; frame_count unchanged. Re-enable gives frame_start 3 cycles later with default latency.
- reset asserted during hsync (raw cx=2010) together with enable=1 → next cycle all outputs at reset values, frame_count=0, no residual hsync cycles.
